// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// Latency: none; this file only carries wires.
// Backpressure: in_ready and out_ready use the usual valid/ready rules.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // The decoder block sits on this side.
    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    // Fetch and the consumer sit on this side.
    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate decoder with a small output FIFO.
// Latency: decode is registered at push and visible one edge later; no in->out comb path.
// Backpressure: in_ready = (count < DEPTH); a full FIFO refuses pushes even while popping.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    logic [31:0]     inst;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            is_shift;
    logic [31:0]     imm32;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [2:0]       fmt_mem [DEPTH];
    logic             ill_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          in_ready;
    logic          out_valid;

    assign inst     = bus.in_inst;
    assign opc      = inst[6:0];
    assign f3       = inst[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Every immediate fits in 32 signed bits; shamt values are small and
    // positive, so one final sign extension to XLEN is correct for all formats.
    assign dec_imm = XLEN'($signed(imm32));

    // Opcode decode into a 32-bit immediate, format code and illegal flag.
    always_comb begin
        imm32   = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (opc)
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0010011: begin
                dec_fmt = FMT_I;
                if (is_shift) begin
                    // RV64 shifts use a 6-bit shamt; funct7 never leaks into imm.
                    if (XLEN == 64) imm32 = {26'b0, inst[25:20]};
                    else            imm32 = {27'b0, inst[24:20]};
                end else begin
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    // Word shifts always take a 5-bit shamt.
                    if (is_shift) imm32 = {27'b0, inst[24:20]};
                    else          imm32 = {{20{inst[31]}}, inst[31:20]};
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b0110011, 7'b0001111: begin
                dec_fmt = FMT_NONE;
            end
            7'b0111011: begin
                dec_ill = (XLEN != 64);
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // FIFO state: reset clears storage, flush only empties it, else push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem[i] <= '0;
                fmt_mem[i] <= '0;
                ill_mem[i] <= 1'b0;
                tag_mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) begin
                imm_mem[wptr] <= dec_imm;
                fmt_mem[wptr] <= dec_fmt;
                ill_mem[wptr] <= dec_ill;
                tag_mem[wptr] <= bus.in_tag;
                wptr          <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_imm     = out_valid ? imm_mem[rptr] : '0;
    assign bus.out_fmt     = out_valid ? fmt_mem[rptr] : '0;
    assign bus.out_illegal = out_valid ? ill_mem[rptr] : 1'b0;
    assign bus.out_tag     = out_valid ? tag_mem[rptr] : '0;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32/DEPTH=2 and XLEN=64/DEPTH=3 instances.
// Drivers push expected results into queues; negedge monitors pop and compare.
// Inputs change 1 time unit after posedge, outputs sampled on negedge.
module tb_imm_gen_pipe;
    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) u32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(3), .TAG_W(32)) u64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b64)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t q32[$];
    exp_t q64[$];
    logic [31:0] tag32 = 32'h0000_1000;
    logic [31:0] tag64 = 32'h0000_2000;

    vec_t v32 [14] = '{
        '{32'hFFF00093, 64'hFFFFFFFF,  3'd1, 1'b0},   // addi -1
        '{32'hFE112E23, 64'hFFFFFFFC,  3'd2, 1'b0},   // sw -4
        '{32'hFFDFF06F, 64'hFFFFFFFC,  3'd5, 1'b0},   // j -4
        '{32'h123450B7, 64'h12345000,  3'd4, 1'b0},   // lui
        '{32'h01F09093, 64'h0000001F,  3'd1, 1'b0},   // slli 31
        '{32'h4010D093, 64'h00000001,  3'd1, 1'b0},   // srai 1
        '{32'h0000007F, 64'h0,         3'd0, 1'b1},   // bad opcode
        '{32'hFE000EE3, 64'hFFFFFFFC,  3'd3, 1'b0},   // beq -4
        '{32'h00000033, 64'h0,         3'd0, 1'b0},   // OP
        '{32'h0000100F, 64'h0,         3'd0, 1'b0},   // fence.i-ish FENCE opcode
        '{32'h0000003B, 64'h0,         3'd0, 1'b1},   // OP-32 illegal on RV32
        '{32'h0000001B, 64'h0,         3'd0, 1'b1},   // OP-IMM-32 illegal on RV32
        '{32'h00008067, 64'h0,         3'd1, 1'b0},   // jalr ret
        '{32'hFFFFF117, 64'hFFFFF000,  3'd4, 1'b0}    // auipc
    };

    vec_t v64 [9] = '{
        '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0},  // lui 0x80000
        '{32'h03F09093, 64'h000000000000003F, 3'd1, 1'b0},  // slli 63
        '{32'h0000003B, 64'h0,                3'd0, 1'b0},  // OP-32 legal
        '{32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},  // addiw -1
        '{32'h0210909B, 64'h0000000000000001, 3'd1, 1'b0},  // slliw, bit25 set
        '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0},  // sw -4
        '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0},  // j -4
        '{32'h4210D093, 64'h0000000000000021, 3'd1, 1'b0},  // srai 33
        '{32'h0000007F, 64'h0,                3'd0, 1'b1}   // bad opcode
    };

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor for the 32-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            q32.delete();
        end else if (b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                chk("pop32_unexpected", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                chk("imm32", {32'b0, b32.out_imm}, e.imm);
                chk("fmt32", {61'b0, b32.out_fmt}, {61'b0, e.fmt});
                chk("ill32", {63'b0, b32.out_illegal}, {63'b0, e.ill});
                chk("tag32", {32'b0, b32.out_tag}, {32'b0, e.tag});
            end
        end else if (!b32.out_valid) begin
            chk("idle32_zero", {28'b0, b32.out_imm, b32.out_fmt, b32.out_illegal}, 64'd0);
            chk("idle32_tag",  {32'b0, b32.out_tag}, 64'd0);
        end
    end

    // Scoreboard monitor for the 64-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            q64.delete();
        end else if (b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) begin
                chk("pop64_unexpected", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                chk("imm64", b64.out_imm, e.imm);
                chk("fmt64", {61'b0, b64.out_fmt}, {61'b0, e.fmt});
                chk("ill64", {63'b0, b64.out_illegal}, {63'b0, e.ill});
                chk("tag64", {32'b0, b64.out_tag}, {32'b0, e.tag});
            end
        end else if (!b64.out_valid) begin
            chk("idle64_imm", b64.out_imm, 64'd0);
            chk("idle64_rest", {28'b0, b64.out_fmt, b64.out_illegal, b64.out_tag}, 64'd0);
        end
    end

    task automatic send32(input vec_t v);
        exp_t e;
        int   n = 0;
        b32.in_valid = 1'b1;
        b32.in_inst  = v.inst;
        b32.in_tag   = tag32;
        forever begin
            @(negedge clk);
            if (b32.in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            chk("send32_timeout", 64'd1, 64'd0);
        end else begin
            e.imm = v.imm; e.fmt = v.fmt; e.ill = v.ill; e.tag = tag32;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        tag32 = tag32 + 32'd1;
    endtask

    task automatic send64(input vec_t v);
        exp_t e;
        int   n = 0;
        b64.in_valid = 1'b1;
        b64.in_inst  = v.inst;
        b64.in_tag   = tag64;
        forever begin
            @(negedge clk);
            if (b64.in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            chk("send64_timeout", 64'd1, 64'd0);
        end else begin
            e.imm = v.imm; e.fmt = v.fmt; e.ill = v.ill; e.tag = tag64;
            q64.push_back(e);
        end
        @(posedge clk);
        #1;
        b64.in_valid = 1'b0;
        tag64 = tag64 + 32'd1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Fill with nq entries, then abort by flush or reset while offering a new push.
    task automatic abort_test(input int nq, input bit use_rst, input string tname);
        vec_t a;
        b32.out_ready = 1'b0;
        for (int i = 0; i < nq; i++) begin
            a = '{32'h00100093, 64'h1, 3'd1, 1'b0};
            send32(a);
        end
        b32.in_valid = 1'b1;
        b32.in_inst  = 32'h00200093;
        b32.in_tag   = 32'hDEAD_BEEF;
        if (use_rst) rst_n = 1'b0;
        else         flush = 1'b1;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        flush        = 1'b0;
        b32.in_valid = 1'b0;
        chk({tname, "_out_valid"}, {63'b0, b32.out_valid}, 64'd0);
        chk({tname, "_out_imm"},   {32'b0, b32.out_imm}, 64'd0);
        chk({tname, "_fmt_ill"},   {60'b0, b32.out_fmt, b32.out_illegal}, 64'd0);
        chk({tname, "_out_tag"},   {32'b0, b32.out_tag}, 64'd0);
        chk({tname, "_in_ready"},  {63'b0, b32.in_ready}, 64'd1);
        b32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tname, "_dropped"}, {63'b0, b32.out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t a;
        logic [31:0] tag_head;
        bit   c_done;
        int   n;

        rst_n = 1'b0;
        flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst32_in_ready",  {63'b0, b32.in_ready}, 64'd1);
        chk("rst32_out_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("rst32_outs",      {28'b0, b32.out_imm, b32.out_fmt, b32.out_illegal}, 64'd0);
        chk("rst64_in_ready",  {63'b0, b64.in_ready}, 64'd1);
        chk("rst64_out_valid", {63'b0, b64.out_valid}, 64'd0);
        chk("rst64_imm",       b64.out_imm, 64'd0);

        // Decode table, RV32, consumer always ready.
        for (int i = 0; i < 14; i++) send32(v32[i]);
        drain();

        // Decode table, RV64, 3-deep FIFO filled first then streamed.
        b64.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send64(v64[i]);
        chk("fill64_in_ready", {63'b0, b64.in_ready}, 64'd0);
        b64.out_ready = 1'b1;
        for (int i = 3; i < 9; i++) send64(v64[i]);
        drain();

        // Backpressure on the 2-deep RV32 FIFO.
        b32.out_ready = 1'b0;
        tag_head = tag32;
        a = '{32'h00100093, 64'h1, 3'd1, 1'b0};
        send32(a);
        a = '{32'h00200093, 64'h2, 3'd1, 1'b0};
        send32(a);
        chk("bp_in_ready_full", {63'b0, b32.in_ready}, 64'd0);
        chk("bp_out_valid",     {63'b0, b32.out_valid}, 64'd1);
        c_done = 1'b0;
        fork
            begin
                vec_t c;
                c = '{32'h00300093, 64'h3, 3'd1, 1'b0};
                send32(c);
                c_done = 1'b1;
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_in_ready", {63'b0, b32.in_ready}, 64'd0);
        chk("bp_head_tag",      {32'b0, b32.out_tag}, {32'b0, tag_head});
        b32.out_ready = 1'b1;
        n = 0;
        while (!c_done && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (!c_done) chk("bp_third_timeout", 64'd1, 64'd0);
        #1;
        a = '{32'h00400093, 64'h4, 3'd1, 1'b0};
        send32(a);
        a = '{32'hFFC00093, 64'hFFFFFFFC, 3'd1, 1'b0};
        send32(a);
        drain();

        // Aborts: flush with a full FIFO, flush with room (push must drop), reset mid-stream.
        abort_test(2, 1'b0, "flush_full");
        abort_test(1, 1'b0, "flush_push");
        abort_test(2, 1'b1, "reset_mid");

        // Traffic still flows correctly after the aborts.
        send32(v32[0]);
        send32(v32[7]);
        drain();
        chk("final_q32_empty", 64'(q32.size()), 64'd0);
        chk("final_q64_empty", 64'(q64.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. Accepts one RV32I/RV64I instruction per cycle over a valid/ready handshake and decodes its format. Produces a single muxed, sign-extended immediate, a format code and an illegal-opcode flag, all buffered in a small output FIFO. Sits between fetch and the decode/execute register stage and carries a sideband tag (e.g. PC) alongside each instruction.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; controls sign-extension width and shamt width.
DEPTH, 2, output FIFO entries; legal values 1 to 4.
TAG_W, 32, width of the sideband tag carried with each instruction.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  instruction present
in_ready  output  1  block can accept an instruction
in_inst  input  32  raw instruction
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_imm  output  XLEN  decoded immediate
out_fmt  output  3  0=NONE 1=I 2=S 3=B 4=U 5=J
out_illegal  output  1  opcode not recognised
out_tag  output  TAG_W  tag of head entry

Behaviour:
- Reset (rst_n=0 at a rising edge): count=0, read/write pointers=0, all storage cleared. out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, in_ready=1 on the following cycle.
- Push = in_valid & in_ready; pop = out_valid & out_ready; in_ready = (count < DEPTH). There is no combinational in->out path.
- Latency: an instruction pushed at edge N appears at out_* from edge N onward if the FIFO was empty. Order is strict FIFO.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, in_ready=0, so no push occurs even if a pop happens that cycle.
- Data outputs show the head entry; when out_valid=0 all data outputs are forced to 0.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- flush=1: count=0, pointers=0, any same-cycle push is dropped, out_valid=0 the next cycle. Reset has priority over flush.
- Decode by opcode = inst[6:0]. Sign bit is inst[31], extended to XLEN:
  - I (fmt 1): 0000011 load, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM; imm = sext(inst[31:20]).
  - I shifts: OP-IMM with funct3 001/101, and XLEN=64 OP-IMM-32 (0011011) shifts, give imm = zero-extended shamt. Shamt is inst[24:20] for XLEN=32 and for OP-IMM-32; it is inst[25:20] for XLEN=64 OP-IMM. funct7 bits never appear in imm.
  - S (fmt 2): 0100011; imm = sext({inst[31:25],inst[11:7]}).
  - B (fmt 3): 1100011; imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - U (fmt 4): 0110111, 0010111; imm = sext({inst[31:12],12'b0}). For XLEN=64, bit 31 is extended.
  - J (fmt 5): 1101111; imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - NONE (fmt 0), imm=0, legal: 0110011 OP, 0001111 FENCE. XLEN=64 only: 0111011 OP-32 (legal, NONE) and 0011011 OP-IMM-32 (I-type, shift rule above).
  - Any other opcode, including XLEN=64-only opcodes when XLEN=32: fmt 0, imm 0, out_illegal=1. The entry is still queued and popped normally.
- Decode is computed at push and stored, not recomputed at the output.

Test Plan:
- XLEN=32. Push 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, imm 0xFFFFFFFF, fmt 1, illegal 0, tag echoed.
- Push 0xFE112E23 (sw -4), then 0xFFDFF06F (j -4) -> imm 0xFFFFFFFC fmt 2, then imm 0xFFFFFFFC fmt 5, in order. Push 0x123450B7 (lui) -> imm 0x12345000 fmt 4.
- Push 0x01F09093 (slli 31) -> imm 0x0000001F; push 0x4010D093 (srai 1) -> imm 0x00000001; push 0x0000007F -> fmt 0, imm 0, illegal 1.
- XLEN=64. Push 0x800000B7 (lui 0x80000) -> imm 0xFFFFFFFF80000000. Push 0x03F09093 (slli 63) -> imm 0x3F. Push 0x0000003B -> fmt 0, illegal 0.
- DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready=0 after 2nd push, 3rd held. Raise out_ready with in_valid held -> push and pop in the same cycle, FIFO order kept, count never exceeds 2.
- With 2 entries queued: assert flush together with in_valid -> next cycle out_valid=0, outputs 0, input dropped. Repeat with rst_n=0 mid-stream -> same, and in_ready=1 after reset.
